// File: rtl/bus_tmo.sv
// rtl/bus_tmo.sv - CPU bus timeout monitor with forced ack, fault capture and status register
module bus_tmo #(
   parameter int timeout_cycles = 1024,
   parameter int cnt_w          = $clog2(timeout_cycles)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_stb,
   input  logic        bus_we,
   input  logic [21:0] bus_addr,
   input  logic        slv_ack,
   output logic        bus_ack,
   output logic        tmo_trig,
   input  logic        stb,
   input  logic        we,
   input  logic [1:0]  data_in,
   output logic [31:0] data_out,
   output logic        ack
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] WAIT = 1'b1;
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles - 1);

   logic [0:0]       state;
   logic [cnt_w-1:0] cnt;
   logic             en;
   logic             cap_valid;
   logic             cap_we;
   logic [21:0]      cap_addr;
   logic [7:0]       err_cnt;
   logic             tout;
   logic             wr;
   logic             clr;

   // A slave ack in the final cycle suppresses the timeout entirely.
   assign tout     = bus_stb & en & ~slv_ack & (cnt == cnt_last);
   assign bus_ack  = slv_ack | tout;
   assign tmo_trig = tout;

   assign wr  = stb & we;
   assign clr = wr & data_in[0];

   assign ack      = stb;
   assign data_out = stb ? {cap_valid, cap_we, err_cnt, cap_addr} : 32'd0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         en        <= 1'b1;
         cap_valid <= 1'b0;
         cap_we    <= 1'b0;
         cap_addr  <= '0;
         err_cnt   <= '0;
      end else begin
         cnt <= (bus_stb & en & ~bus_ack) ? cnt + cnt_w'(1) : '0;

         case (state)
            IDLE: if (bus_stb & en & ~slv_ack) state <= WAIT;
            WAIT: if (bus_ack | ~bus_stb | ~en) state <= IDLE;
            default: state <= IDLE;
         endcase

         if (wr) en <= data_in[1];

         // A clear landing on a timeout edge is overridden: the new fault is recorded fresh.
         if (tout) begin
            if (!cap_valid || clr) begin
               cap_valid <= 1'b1;
               cap_we    <= bus_we;
               cap_addr  <= bus_addr;
            end
            if (clr)                  err_cnt <= 8'd1;
            else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
         end else if (clr) begin
            cap_valid <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            err_cnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_bus_tmo.sv
// tb/tb_bus_tmo.sv - scoreboard testbench for bus_tmo
module tb_bus_tmo;

   localparam int TMO = 8;

   typedef struct {
      int cyc;
      bit trig;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        bus_stb;
   logic        bus_we;
   logic [21:0] bus_addr;
   logic        slv_ack;
   logic        bus_ack;
   logic        tmo_trig;
   logic        stb;
   logic        we;
   logic [1:0]  data_in;
   logic [31:0] data_out;
   logic        ack;

   int n_checks = 0;
   int n_errors = 0;

   exp_t sb_q[$];

   bit          m_en;
   bit          m_cv;
   bit          m_cw;
   logic [21:0] m_addr;
   int          m_err;

   bus_tmo #(.timeout_cycles(TMO)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus_stb  (bus_stb),
      .bus_we   (bus_we),
      .bus_addr (bus_addr),
      .slv_ack  (slv_ack),
      .bus_ack  (bus_ack),
      .tmo_trig (tmo_trig),
      .stb      (stb),
      .we       (we),
      .data_in  (data_in),
      .data_out (data_out),
      .ack      (ack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_word();
      logic [7:0] e;
      e = 8'(m_err);
      return {m_cv, m_cw, e, m_addr};
   endfunction

   task automatic model_reset();
      m_en   = 1'b1;
      m_cv   = 1'b0;
      m_cw   = 1'b0;
      m_addr = '0;
      m_err  = 0;
   endtask

   // One CPU access; ack_at = cycle the slave answers (0 = never); optional register write at wr_at.
   task automatic bus_access(input logic [21:0] a, input logic w, input int ack_at, input int limit,
                             input bit keep_stb, input int wr_at, input logic [1:0] wd);
      exp_t e;
      exp_t g;
      bit   slave_in_time;
      g.cyc  = 0;
      g.trig = 1'b0;
      slave_in_time = (ack_at > 0) && (ack_at <= TMO);
      if (m_en) begin
         e.cyc  = slave_in_time ? ack_at : TMO;
         e.trig = !slave_in_time;
      end else begin
         e.cyc  = ack_at;
         e.trig = 1'b0;
      end
      sb_q.push_back(e);

      bus_stb  = 1'b1;
      bus_addr = a;
      bus_we   = w;
      for (int c = 1; c <= limit; c++) begin
         slv_ack = (c == ack_at);
         stb     = (c == wr_at);
         we      = (c == wr_at);
         data_in = wd;
         #1;
         if (bus_ack) begin
            g.cyc  = c;
            g.trig = tmo_trig;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      slv_ack = 1'b0;
      stb     = 1'b0;
      we      = 1'b0;
      if (!keep_stb) bus_stb = 1'b0;

      if (wr_at > 0 && wr_at <= e.cyc && wd[0]) begin
         m_cv = 1'b0; m_cw = 1'b0; m_addr = '0; m_err = 0;
      end
      if (e.trig) begin
         if (!m_cv) begin
            m_cv = 1'b1; m_cw = w; m_addr = a;
         end
         if (m_err < 255) m_err++;
      end
      if (wr_at > 0 && wr_at <= e.cyc) m_en = wd[1];

      e = sb_q.pop_front();
      chk("ack_cycle", g.cyc, e.cyc);
      chk("trig_on_ack", {31'd0, g.trig}, {31'd0, e.trig});
   endtask

   task automatic reg_read(input string tag);
      stb = 1'b1;
      we  = 1'b0;
      #1;
      chk(tag, data_out, m_word());
      chk("reg_ack", {31'd0, ack}, 32'd1);
      @(negedge clk);
      stb = 1'b0;
   endtask

   task automatic reg_write(input logic [1:0] d);
      stb     = 1'b1;
      we      = 1'b1;
      data_in = d;
      @(negedge clk);
      stb = 1'b0;
      we  = 1'b0;
      if (d[0]) begin
         m_cv = 1'b0; m_cw = 1'b0; m_addr = '0; m_err = 0;
      end
      m_en = d[1];
   endtask

   initial begin
      int trig_seen;
      rst_n    = 1'b0;
      bus_stb  = 1'b0;
      bus_we   = 1'b0;
      bus_addr = '0;
      slv_ack  = 1'b0;
      stb      = 1'b0;
      we       = 1'b0;
      data_in  = 2'b00;
      model_reset();

      #1;
      chk("rst_trig", {31'd0, tmo_trig}, 32'd0);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_dout", data_out, 32'd0);
      slv_ack = 1'b1;
      #1;
      chk("rst_bus_ack_follows", {31'd0, bus_ack}, 32'd1);
      slv_ack = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      reg_read("rst_reg");

      // Read of 0xFFFFA0 hangs and is forced in cycle 8.
      bus_access(22'h3FFFE8, 1'b0, 0, 20, 1'b0, 0, 2'b00);
      stb = 1'b1;
      #1;
      chk("first_fault_word", data_out, 32'h80000000 | (32'd1 << 22) | 32'h003FFFE8);
      @(negedge clk);
      stb = 1'b0;

      // Back-to-back with stb held: first answered in cycle 3, second timed from zero.
      bus_access(22'h000100, 1'b0, 3, 20, 1'b1, 0, 2'b00);
      bus_access(22'h000104, 1'b1, 0, 20, 1'b0, 0, 2'b00);
      reg_read("after_b2b");

      // Slave answers exactly in the timeout cycle.
      bus_access(22'h000200, 1'b0, TMO, 20, 1'b0, 0, 2'b00);
      reg_read("slave_wins");

      reg_write(2'b11);
      reg_read("after_clear");
      bus_access(22'h001000, 1'b1, 0, 20, 1'b0, 0, 2'b00);
      bus_access(22'h002222, 1'b0, 0, 20, 1'b0, 0, 2'b00);
      reg_read("first_fault_held");

      for (int i = 0; i < 256; i++)
         bus_access(22'(i * 4 + 8), i[0], 0, 20, 1'b0, 0, 2'b00);
      reg_read("err_saturated");

      // Clear+enable lands on the forced-ack edge.
      bus_access(22'h0ABCDE, 1'b0, 0, 20, 1'b0, TMO, 2'b11);
      reg_read("clear_vs_tout");

      reg_write(2'b01);
      reg_read("cleared_disabled");
      bus_access(22'h000300, 1'b0, 0, 40, 1'b0, 0, 2'b00);
      reg_write(2'b10);

      // Reset in cycle 5 of a hung access.
      bus_stb  = 1'b1;
      bus_addr = 22'h000400;
      bus_we   = 1'b0;
      trig_seen = 0;
      for (int c = 1; c <= 4; c++) begin
         #1;
         if (bus_ack || tmo_trig) trig_seen++;
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      chk("rst_mid_bus_ack", {31'd0, bus_ack}, 32'd0);
      chk("rst_mid_trig", {31'd0, tmo_trig}, 32'd0);
      bus_stb = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (tmo_trig) trig_seen++;
         @(negedge clk);
      end
      chk("rst_no_trig", trig_seen, 32'd0);
      reg_read("rst_release_reg");

      bus_access(22'h000500, 1'b1, 0, 20, 1'b0, 0, 2'b00);
      reg_read("post_reset_fault");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
